transcr_ctrl: RTL
=================

Name: transcr_ctrl

Overview:
- Sequences one frame of Y/Cr pixels through the transcr pipeline, which has no valid signal and cannot stall.
- Tracks in-flight pixels with a valid/sideband shift register matched to transcr latency.
- Results land in an output FIFO with ready/valid backpressure.
- Credit-based issue ensures a stalled consumer never loses a result.

Parameters:
LATENCY, 6, clock edges from input acceptance to the transcr result being capturable (edge E accepted -> captured at edge E+LATENCY)
FIFO_DEPTH, 8, output FIFO entries (power of two, >= LATENCY)
DIM_W, 11, width of frame dimension config and counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse; latches cfg_width/cfg_height, begins frame
cfg_width  in  DIM_W  pixels per line (0 treated as 1)
cfg_height  in  DIM_W  lines per frame (0 treated as 1)
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle pulse when frame fully drained
in_valid  in  1  input pixel valid
in_ready  out  1  controller accepts pixel this cycle
in_y  in  8  luma
in_cr  in  8  Cr
tc_y  out  8  to transcr Y (combinational pass-through of in_y)
tc_cr  out  8  to transcr Cr (combinational pass-through of in_cr)
tc_out  in  8  transcr result
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts
out_data  out  8  transformed Cr (first-word fall-through)
out_eol  out  1  last pixel of line
out_eof  out  1  last pixel of frame

Behaviour:
- Reset (async) clears: state=IDLE, busy=0, done=0, in_ready=0, out_valid=0, out_data=0, out_eol=0, out_eof=0, x/y counters, shift register, FIFO pointers and count.
- transcr internals are not reset. Garbage in transcr is discarded because all shift-register valid bits are cleared.
- FSM IDLE -> RUN on start (ignored outside IDLE). Entering RUN latches max(cfg,1) for width and height; x=y=0.
- RUN: in_ready = (fifo_count + inflight) < FIFO_DEPTH. inflight = popcount of the shift-register valid bits.
- Accept when in_valid && in_ready. This pushes {1, eol=(x==W-1), eof=eol&&(y==H-1)} into the shift register and advances x; y advances on eol.
- Accepting the eof pixel: RUN -> DRAIN. in_ready=0 from the next cycle.
- Shift register is LATENCY deep and shifts every cycle. On the edge where the tail bit is valid, tc_out plus sidebands are written to the FIFO.
- Credit accounting guarantees this write never overflows. If an overflow still occurs, an assertion fires in simulation.
- DRAIN -> IDLE when inflight==0 and FIFO empty, with a done pulse in the same cycle as the transition. done is registered, high for one cycle.
- FIFO: pop when out_valid && out_ready. Simultaneous push and pop at full or empty are both legal, and count is unchanged.
- Outputs are in issue order; no reordering.
- Throughput: one pixel/cycle sustained when out_ready=1.
- Start latency: first in_ready the cycle after start. First out_valid LATENCY cycles after the first accept.
- rst asserted mid-frame aborts immediately. No done pulse. After release, stays IDLE until start.
- in_valid while IDLE/DRAIN is ignored (in_ready=0).

Optional Feature:
- Macro TRANSCR_CTRL_STATS_EN.
- Defined: adds outputs stall_cycles[31:0] and frame_count[15:0], both reset to 0.
  - stall_cycles increments each RUN cycle with in_valid=1 and in_ready=0. It clears on start.
  - frame_count increments on each done and wraps at 65535->0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- W=4, H=2, in_valid=1 always, out_ready=1, transcr model = identity delay of LATENCY.
  - Expect 8 outputs, equal to inputs in order.
  - First out_valid 6 cycles after first accept.
  - out_eol on outputs 3 and 7; out_eof on 7 only.
  - done exactly one cycle after last pop.
- Backpressure: W=16, H=1, out_ready=0 throughout.
  - in_ready drops after exactly 8 accepts; out_valid held.
  - Then out_ready=1: all 16 outputs emerge, none lost or duplicated.
- cfg_width=0, cfg_height=0: one pixel accepted with eol=eof=1; done pulses; FSM returns to IDLE.
- Reset mid-frame after 3 accepts:
  - All outputs zero immediately.
  - No FIFO write from in-flight pixels, no done.
  - New start W=2, H=1 produces exactly 2 clean outputs.
- Random out_ready (50%) and random in_valid, W=37, H=5:
  - 185 outputs in order.
  - fifo_count + inflight never exceeds 8.
  - With TRANSCR_CTRL_STATS_EN, frame_count=1 and stall_cycles matches the bench count.
- start pulsed during RUN and DRAIN: ignored; config unchanged; single done.

Source files
------------

// File: rtl/transcr_ctrl.sv
// Frame sequencer for the stall-free transcr pipeline: credit-gated issue, latency-matched
// valid/sideband tracking and an output FIFO. Define TRANSCR_CTRL_STATS_EN for stall/frame counters.
module transcr_ctrl #(
  parameter int unsigned LATENCY    = 6,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIM_W      = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_y,
  input  logic [7:0]       in_cr,
  output logic [7:0]       tc_y,
  output logic [7:0]       tc_cr,
  input  logic [7:0]       tc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_eol,
  output logic             out_eof
`ifdef TRANSCR_CTRL_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [15:0]      frame_count
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = $clog2(FIFO_DEPTH + LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;
  typedef struct packed {
    logic [7:0] data;
    logic       eol;
    logic       eof;
  } ent_t;

  state_t             state, state_nx;
  logic [DIM_W-1:0]   wid, hgt, x_cnt, y_cnt;
  logic [DIM_W-1:0]   wid_nx, hgt_nx, x_nx, y_nx;
  logic [LATENCY-1:0] sr_vld, sr_eol, sr_eof, sr_vld_nx;
  ent_t               mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_ptr_nx;
  logic [CNT_W-1:0]   count, count_nx;
  logic               accept, eol_c, eof_c, push, pop, done_nx, in_ready_nx;
  ent_t               push_ent, head_nx;

  assign tc_y  = in_y;
  assign tc_cr = in_cr;

  function automatic logic [SUM_W-1:0] popcnt(input logic [LATENCY-1:0] v);
    popcnt = '0;
    for (int i = 0; i < LATENCY; i++) popcnt = popcnt + SUM_W'(v[i]);
  endfunction

  // Next-state for the frame FSM, pixel counters, shift register and FIFO
  always_comb begin
    state_nx = state;
    wid_nx   = wid;
    hgt_nx   = hgt;
    x_nx     = x_cnt;
    y_nx     = y_cnt;
    done_nx  = 1'b0;
    accept   = in_valid && in_ready;
    eol_c    = (x_cnt == wid - DIM_W'(1));
    eof_c    = eol_c && (y_cnt == hgt - DIM_W'(1));
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_RUN;
          wid_nx   = (cfg_width == '0) ? DIM_W'(1) : cfg_width;
          hgt_nx   = (cfg_height == '0) ? DIM_W'(1) : cfg_height;
          x_nx     = '0;
          y_nx     = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (eol_c) begin
            x_nx = '0;
            y_nx = y_cnt + DIM_W'(1);
          end else begin
            x_nx = x_cnt + DIM_W'(1);
          end
          if (eof_c) state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (sr_vld == '0 && count == '0) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    push      = sr_vld[LATENCY-1];
    pop       = out_valid && out_ready;
    push_ent  = '{data: tc_out, eol: sr_eol[LATENCY-1], eof: sr_eof[LATENCY-1]};
    rd_ptr_nx = rd_ptr + PTR_W'(pop);
    count_nx  = count + CNT_W'(push) - CNT_W'(pop);
    // A push into an otherwise-empty FIFO becomes the new head directly
    head_nx   = (push && count == CNT_W'(pop)) ? push_ent : mem[rd_ptr_nx];
    sr_vld_nx = {sr_vld[LATENCY-2:0], accept};
    in_ready_nx = (state_nx == S_RUN) &&
                  ((SUM_W'(count_nx) + popcnt(sr_vld_nx)) < SUM_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wid       <= '0;
      hgt       <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      sr_vld    <= '0;
      sr_eol    <= '0;
      sr_eof    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      wid       <= wid_nx;
      hgt       <= hgt_nx;
      x_cnt     <= x_nx;
      y_cnt     <= y_nx;
      sr_vld    <= sr_vld_nx;
      sr_eol    <= {sr_eol[LATENCY-2:0], accept & eol_c};
      sr_eof    <= {sr_eof[LATENCY-2:0], accept & eof_c};
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr    <= rd_ptr_nx;
      count     <= count_nx;
      busy      <= (state_nx != S_IDLE);
      done      <= done_nx;
      in_ready  <= in_ready_nx;
      out_valid <= (count_nx != '0);
      out_data  <= (count_nx != '0) ? head_nx.data : 8'h00;
      out_eol   <= (count_nx != '0) && head_nx.eol;
      out_eof   <= (count_nx != '0) && head_nx.eof;
    end
  end

  // Storage is not reset; only entries below count are ever observed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_ent;
  end

`ifdef TRANSCR_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      frame_count  <= '0;
    end else begin
      if (state == S_IDLE && start)                     stall_cycles <= '0;
      else if (state == S_RUN && in_valid && !in_ready) stall_cycles <= stall_cycles + 32'd1;
      if (done_nx) frame_count <= frame_count + 16'd1;
    end
  end
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count == CNT_W'(FIFO_DEPTH)));

endmodule
